// File: rtl/cmd_rx_pkt_pkg.sv
// Shared constants for the command packet receiver: framing byte, op encodings
// and CRC polynomial.
package cmd_rx_pkt_pkg;

  localparam logic [7:0] CMD_RX_START  = 8'hA5;

  localparam logic [2:0] CMD_OP_NOP    = 3'd0;
  localparam logic [2:0] CMD_OP_MREAD  = 3'd1;
  localparam logic [2:0] CMD_OP_MWRITE = 3'd2;
  localparam logic [2:0] CMD_OP_STALL  = 3'd3;

  // CRC-8, x^8 + x^2 + x + 1, MSB first, no reflection
  localparam logic [7:0] CRC8_POLY     = 8'h07;

  function automatic logic op_known(input logic [2:0] op);
    return (op == CMD_OP_NOP) || (op == CMD_OP_MREAD) ||
           (op == CMD_OP_MWRITE) || (op == CMD_OP_STALL);
  endfunction

endpackage

// File: rtl/cmd_rx_pkt_crc8.sv
// Combinational one-byte CRC-8 update: o_crc = crc8(i_crc, i_data).
module cmd_rx_pkt_crc8
  import cmd_rx_pkt_pkg::*;
(
  input  logic [7:0] i_data,
  input  logic [7:0] i_crc,
  output logic [7:0] o_crc
);

  always_comb begin
    logic [7:0] c;
    c = i_crc ^ i_data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    o_crc = c;
  end

endmodule

// File: rtl/cmd_rx_pkt.sv
// Byte-stream command packet receiver: frames START/OP/SIZE/ADDR/CRC packets,
// checks CRC-8 and hands memory requests to a single-entry holding register.
//
// state   | meaning
// IDLE    | hunting for the START byte, other bytes dropped
// OP      | next byte is the op byte
// SIZE    | collecting word-count bytes, LS first
// ADDR    | collecting address bytes, LS first
// CRC     | next byte is the CRC, packet is resolved on acceptance
// STALL   | halted until reset, nothing accepted
module cmd_rx_pkt
  import cmd_rx_pkt_pkg::*;
#(
  parameter  int ADDR_BYTES     = 4,
  parameter  int SIZE_BYTES     = 1,
  parameter  int TIMEOUT_CYCLES = 1024,
  parameter  int CNT_W          = 8,
  localparam int ADDR_W         = 8 * ADDR_BYTES,
  localparam int SIZE_W         = 8 * SIZE_BYTES
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_mreq_valid,
  input  logic              i_mreq_ready,
  output logic              o_mreq_wr,
  output logic [1:0]        o_mreq_wsize,
  output logic              o_mreq_aincr,
  output logic [SIZE_W-1:0] o_mreq_size,
  output logic [ADDR_W-1:0] o_mreq_addr,
  output logic              o_err_crc,
  output logic              o_err_timeout,
  output logic              o_err_op,
  output logic [CNT_W-1:0]  o_cnt_crc,
  output logic [CNT_W-1:0]  o_cnt_timeout,
  output logic              o_stalled
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_OP    = 3'd1;
  localparam logic [2:0] S_SIZE  = 3'd2;
  localparam logic [2:0] S_ADDR  = 3'd3;
  localparam logic [2:0] S_CRC   = 3'd4;
  localparam logic [2:0] S_STALL = 3'd5;

  localparam logic [1:0] SIZE_LAST = 2'(SIZE_BYTES - 1);
  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD =
    (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [2:0]        state;
  logic [1:0]        idx;
  logic [7:0]        crc_q, crc_nxt;
  logic [2:0]        op_q;
  logic              aincr_q;
  logic [1:0]        wsize_q;
  logic [SIZE_W-1:0] size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              accept, crc_done, crc_good, mreq_take, tmo_run, tmo_hit;

  // chain is seeded with 0 when the START byte is hashed in IDLE
  cmd_rx_pkt_crc8 u_crc8 (
    .i_data (i_rx_data),
    .i_crc  ((state == S_IDLE) ? 8'h00 : crc_q),
    .o_crc  (crc_nxt)
  );

  assign o_rx_ready = (state != S_STALL) &&
                      !(state == S_CRC && o_mreq_valid && !i_mreq_ready);
  assign accept     = i_rx_valid && o_rx_ready;
  assign crc_done   = accept && (state == S_CRC);
  assign crc_good   = (crc_nxt == 8'h00);
  assign mreq_take  = crc_done && crc_good &&
                      (op_q == CMD_OP_MREAD || op_q == CMD_OP_MWRITE);
  assign o_err_crc  = crc_done && !crc_good;
  assign o_err_op   = crc_done && crc_good && !op_known(op_q);
  assign o_stalled  = (state == S_STALL);

  // the timer only runs while a partial packet is waiting on the sender
  assign tmo_run = (TIMEOUT_CYCLES != 0) && !accept &&
                   ((state == S_OP) || (state == S_SIZE) || (state == S_ADDR) ||
                    (state == S_CRC && o_rx_ready));
  assign tmo_hit = tmo_run && (tmo_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      crc_q         <= '0;
      op_q          <= '0;
      aincr_q       <= 1'b0;
      wsize_q       <= '0;
      size_q        <= '0;
      addr_q        <= '0;
      tmo_cnt       <= TMO_LOAD;
      o_err_timeout <= 1'b0;
    end else begin
      o_err_timeout <= tmo_hit;
      if (accept) begin
        tmo_cnt <= TMO_LOAD;
        crc_q   <= crc_nxt;
      end else if (tmo_run) begin
        tmo_cnt <= tmo_cnt - TMO_W'(1);
      end

      if (tmo_hit) begin
        state <= S_IDLE;
      end else if (accept) begin
        case (state)
          S_IDLE: if (i_rx_data == CMD_RX_START) state <= S_OP;
          S_OP: begin
            op_q    <= i_rx_data[2:0];
            aincr_q <= i_rx_data[3];
            wsize_q <= i_rx_data[5:4];
            idx     <= '0;
            state   <= S_SIZE;
          end
          S_SIZE: begin
            size_q <= SIZE_W'({i_rx_data, size_q} >> 8);
            if (idx == SIZE_LAST) begin
              idx   <= '0;
              state <= S_ADDR;
            end else begin
              idx <= idx + 2'd1;
            end
          end
          S_ADDR: begin
            addr_q <= ADDR_W'({i_rx_data, addr_q} >> 8);
            if (idx == ADDR_LAST) state <= S_CRC;
            else                  idx   <= idx + 2'd1;
          end
          S_CRC:   state <= (crc_good && op_q == CMD_OP_STALL) ? S_STALL : S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // holding register: a load can only coincide with a drain, never overwrite
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mreq_valid <= 1'b0;
      o_mreq_wr    <= 1'b0;
      o_mreq_wsize <= '0;
      o_mreq_aincr <= 1'b0;
      o_mreq_size  <= '0;
      o_mreq_addr  <= '0;
    end else if (mreq_take) begin
      o_mreq_valid <= 1'b1;
      o_mreq_wr    <= (op_q == CMD_OP_MWRITE);
      o_mreq_wsize <= wsize_q;
      o_mreq_aincr <= aincr_q;
      o_mreq_size  <= size_q;
      o_mreq_addr  <= addr_q;
    end else if (o_mreq_valid && i_mreq_ready) begin
      o_mreq_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt_crc     <= '0;
      o_cnt_timeout <= '0;
    end else begin
      if (o_err_crc && o_cnt_crc != '1)   o_cnt_crc     <= o_cnt_crc + CNT_W'(1);
      if (tmo_hit && o_cnt_timeout != '1) o_cnt_timeout <= o_cnt_timeout + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cmd_rx_pkt.sv
// Bench for cmd_rx_pkt: packet-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cmd_rx_pkt;
  import cmd_rx_pkt_pkg::*;

  localparam int N   = 8;   // START, OP, 1 size byte, 4 addr bytes, CRC
  localparam int TMO = 16;

  typedef struct packed {
    logic        wr;
    logic [7:0]  size;
    logic [31:0] addr;
    logic        aincr;
    logic [1:0]  wsize;
  } mreq_t;

  logic i_clk = 1'b0, i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, mreq_ready = 1'b1;
  logic        rx_ready, mreq_valid, mreq_wr, mreq_aincr, err_crc, err_tmo, err_op, stalled;
  logic [1:0]  mreq_wsize;
  logic [7:0]  mreq_size, cnt_crc, cnt_tmo;
  logic [31:0] mreq_addr;

  logic [7:0]  r2_data = '0;
  logic        r2_valid = 1'b0;
  logic        r2_ready, m2_valid, m2_wr, m2_aincr, e2_crc, e2_tmo, e2_op, st2;
  logic [1:0]  m2_wsize;
  logic [15:0] m2_size, m2_addr;
  logic [7:0]  c2_crc, c2_tmo;

  cmd_rx_pkt #(.TIMEOUT_CYCLES(TMO)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ready(rx_ready), .o_mreq_valid(mreq_valid), .i_mreq_ready(mreq_ready),
    .o_mreq_wr(mreq_wr), .o_mreq_wsize(mreq_wsize), .o_mreq_aincr(mreq_aincr),
    .o_mreq_size(mreq_size), .o_mreq_addr(mreq_addr), .o_err_crc(err_crc),
    .o_err_timeout(err_tmo), .o_err_op(err_op), .o_cnt_crc(cnt_crc),
    .o_cnt_timeout(cnt_tmo), .o_stalled(stalled));

  cmd_rx_pkt #(.ADDR_BYTES(2), .SIZE_BYTES(2)) u_dut2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_data(r2_data), .i_rx_valid(r2_valid),
    .o_rx_ready(r2_ready), .o_mreq_valid(m2_valid), .i_mreq_ready(1'b1),
    .o_mreq_wr(m2_wr), .o_mreq_wsize(m2_wsize), .o_mreq_aincr(m2_aincr),
    .o_mreq_size(m2_size), .o_mreq_addr(m2_addr), .o_err_crc(e2_crc),
    .o_err_timeout(e2_tmo), .o_err_op(e2_op), .o_cnt_crc(c2_crc),
    .o_cnt_timeout(c2_tmo), .o_stalled(st2));

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07) : {x[6:0], 1'b0};
    return x;
  endfunction

  // ---------------- packet-level reference model ----------------
  int          m_pos = -1;          // bytes of current packet received, -1 = hunting START
  logic [7:0]  m_pkt [N];
  logic [7:0]  m_crc = '0;
  int          m_idle = 0, m_qn = 0;
  logic        m_stalled = 1'b0, m_tmo = 1'b0;
  int          m_cnt_crc = 0, m_cnt_tmo = 0;
  mreq_t       mq[$];
  logic        m_ready;

  assign m_ready = !m_stalled && !(m_pos == N - 1 && m_qn != 0 && !mreq_ready);

  initial begin
    logic rdy, acc;
    logic [2:0] op;
    forever begin
      @(posedge i_clk);
      if (!i_rst_n) begin
        m_pos = -1; m_stalled = 0; m_qn = 0; mq.delete(); m_idle = 0;
        m_tmo = 0; m_cnt_crc = 0; m_cnt_tmo = 0;
      end else begin
        rdy = m_ready;
        acc = rx_valid && rdy;
        m_tmo = 0;
        if (m_qn != 0 && mreq_ready) begin
          void'(mq.pop_front());
          m_qn--;
        end
        if (acc) begin
          m_idle = 0;
          if (m_pos < 0) begin
            if (rx_data == CMD_RX_START) begin
              m_pkt[0] = rx_data; m_crc = crc8(8'h00, rx_data); m_pos = 1;
            end
          end else begin
            m_pkt[m_pos] = rx_data;
            m_crc = crc8(m_crc, rx_data);
            if (m_pos < N - 1) m_pos++;
            else begin
              m_pos = -1;
              op = m_pkt[1][2:0];
              if (m_crc != 8'h00) begin
                if (m_cnt_crc < 255) m_cnt_crc++;
              end else if (op == CMD_OP_MREAD || op == CMD_OP_MWRITE) begin
                mq.push_back('{wr: (op == CMD_OP_MWRITE), size: m_pkt[2],
                               addr: {m_pkt[6], m_pkt[5], m_pkt[4], m_pkt[3]},
                               aincr: m_pkt[1][3], wsize: m_pkt[1][5:4]});
                m_qn++;
              end else if (op == CMD_OP_STALL) m_stalled = 1;
            end
          end
        end else if (m_pos > 0 && (m_pos != N - 1 || rdy)) begin
          m_idle++;
          if (m_idle == TMO) begin
            m_tmo = 1; m_pos = -1; m_idle = 0;
            if (m_cnt_tmo < 255) m_cnt_tmo++;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int          n_mreq = 0, n_err_op = 0;
  logic [31:0] seen_addr [32];

  initial begin
    logic [7:0] c;
    logic in_crc;
    forever begin
      @(negedge i_clk); #2;
      if (i_rst_n) begin
        c = crc8(m_crc, rx_data);
        in_crc = rx_valid && m_ready && (m_pos == N - 1);
        chk("rx_ready", rx_ready, m_ready);
        chk("err_crc", err_crc, in_crc && c != 8'h00);
        chk("err_op", err_op, in_crc && c == 8'h00 && m_pkt[1][2:0] > 3'd3);
        chk("err_timeout", err_tmo, m_tmo);
        chk("cnt_crc", cnt_crc, 64'(m_cnt_crc));
        chk("cnt_timeout", cnt_tmo, 64'(m_cnt_tmo));
        chk("stalled", stalled, m_stalled);
        chk("mreq_valid", mreq_valid, m_qn != 0);
        if (mreq_valid && m_qn != 0)
          chk("mreq_fields", {mreq_wr, mreq_size, mreq_addr, mreq_aincr, mreq_wsize}, mq[0]);
        if (err_op) n_err_op++;
        if (mreq_valid && mreq_ready) begin
          if (n_mreq < 32) seen_addr[n_mreq] = mreq_addr;
          n_mreq++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] pkt [N];

  task automatic build(input logic [7:0] opb, input logic [7:0] sz,
                       input logic [31:0] addr, input logic [7:0] crc_xor);
    logic [7:0] c;
    pkt[0] = CMD_RX_START; pkt[1] = opb; pkt[2] = sz;
    for (int i = 0; i < 4; i++) pkt[3 + i] = addr[8*i +: 8];
    c = 8'h00;
    for (int i = 0; i < N - 1; i++) c = crc8(c, pkt[i]);
    pkt[N - 1] = c ^ crc_xor;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge i_clk);
    rx_data = b; rx_valid = 1'b1;
    #1;
    n = 0;
    while (!m_ready && n < 300) begin
      @(negedge i_clk); #1;
      n++;
    end
    if (!m_ready) chk("send_bound", 1, 0);
    @(posedge i_clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input int n);
    for (int i = 0; i < n; i++) send_byte(pkt[i]);
  endtask

  task automatic send2(input logic [7:0] b);
    @(negedge i_clk);
    r2_data = b; r2_valid = 1'b1;
    @(posedge i_clk); #1;
    r2_valid = 1'b0;
  endtask

  task automatic send2_pkt(input logic [7:0] opb, input logic [15:0] sz,
                           input logic [15:0] addr, input logic [7:0] crc_xor);
    logic [7:0] b [7];
    logic [7:0] c;
    b = '{CMD_RX_START, opb, sz[7:0], sz[15:8], addr[7:0], addr[15:8], 8'h00};
    c = 8'h00;
    for (int i = 0; i < 6; i++) c = crc8(c, b[i]);
    b[6] = c ^ crc_xor;
    for (int i = 0; i < 7; i++) send2(b[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n0, k, lo;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("reset_ready", rx_ready, 1);
    chk("reset_valid", mreq_valid, 0);
    chk("reset_cnt_crc", cnt_crc, 0);
    chk("reset_stalled", stalled, 0);

    // good MWRITE: op=2, aincr=1, wsize=2
    build(8'h2A, 8'h10, 32'h1234_5678, 8'h00);
    send_pkt(N);
    chk("wr_valid", mreq_valid, 1);
    chk("wr_fields", {mreq_wr, mreq_size, mreq_addr, mreq_aincr, mreq_wsize},
        {1'b1, 8'h10, 32'h1234_5678, 1'b1, 2'd2});
    repeat (4) @(negedge i_clk);
    chk("wr_count", n_mreq, 1);

    // corrupted CRC, then the good packet again
    build(8'h2A, 8'h10, 32'h1234_5678, 8'h01);
    send_pkt(N);
    chk("badcrc_cnt", cnt_crc, 1);
    repeat (4) @(negedge i_clk);
    chk("badcrc_nomreq", n_mreq, 1);
    build(8'h2A, 8'h10, 32'h1234_5678, 8'h00);
    send_pkt(N);
    repeat (4) @(negedge i_clk);
    chk("after_bad_count", n_mreq, 2);

    // NOP and unknown op: no request; unknown op flags once
    build(8'h00, 8'h01, 32'h0, 8'h00);
    send_pkt(N);
    build(8'h05, 8'h01, 32'h0, 8'h00);
    send_pkt(N);
    repeat (4) @(negedge i_clk);
    chk("nop_badop_count", n_mreq, 2);
    chk("badop_pulses", n_err_op, 1);

    // back-to-back MREADs against a stalled consumer
    @(negedge i_clk); mreq_ready = 1'b0;
    n0 = n_mreq;
    build(8'h01, 8'h04, 32'hAAAA_0001, 8'h00);
    send_pkt(N);
    build(8'h01, 8'h08, 32'hBBBB_0002, 8'h00);
    fork
      send_pkt(N);
      begin
        repeat (20) @(negedge i_clk);
        #3 chk("crc_blocked_ready", rx_ready, 0);
        @(negedge i_clk); mreq_ready = 1'b1;
      end
    join
    repeat (5) @(negedge i_clk);
    chk("b2b_count", n_mreq, n0 + 2);
    chk("b2b_first", seen_addr[n0], 32'hAAAA_0001);
    chk("b2b_second", seen_addr[n0 + 1], 32'hBBBB_0002);

    // timeout after the third address byte
    build(8'h01, 8'h02, 32'h0403_0201, 8'h00);
    send_pkt(6);
    k = 0;
    while (k < 40) begin
      @(posedge i_clk); #1;
      k++;
      if (err_tmo) break;
    end
    chk("tmo_latency", k, 16);
    chk("tmo_cnt", cnt_tmo, 1);
    n0 = n_mreq;
    build(8'h01, 8'h02, 32'h0403_0201, 8'h00);
    send_pkt(N);
    repeat (4) @(negedge i_clk);
    chk("after_tmo_count", n_mreq, n0 + 1);

    // reset with a pending request and a partial packet
    @(negedge i_clk); mreq_ready = 1'b0;
    n0 = n_mreq;
    build(8'h2A, 8'h33, 32'hDEAD_BEEF, 8'h00);
    send_pkt(N);
    send_pkt(2);
    @(negedge i_clk); i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1; mreq_ready = 1'b1;
    #1 chk("rst_pending_valid", mreq_valid, 0);
    repeat (10) @(negedge i_clk);
    chk("rst_pending_count", n_mreq, n0);

    // STALL then reset
    build(8'h03, 8'h00, 32'h0, 8'h00);
    send_pkt(N);
    @(negedge i_clk); rx_data = CMD_RX_START; rx_valid = 1'b1;
    lo = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk); #1;
      if (!rx_ready && stalled) lo++;
    end
    chk("stall_cycles", lo, 100);
    @(negedge i_clk); rx_valid = 1'b0; i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("stall_rst_ready", rx_ready, 1);
    chk("stall_rst_stalled", stalled, 0);
    chk("stall_rst_cnt_crc", cnt_crc, 0);
    chk("stall_rst_cnt_tmo", cnt_tmo, 0);

    // narrow instance: CRC counter saturation and 16-bit address
    for (int i = 0; i < 300; i++) send2_pkt(8'h02, 16'h0000, 16'h0000, 8'hFF);
    @(negedge i_clk);
    chk("sat_cnt_crc", c2_crc, 255);
    send2_pkt(8'h02, 16'h0102, 16'hBEEF, 8'h00);
    k = 0;
    while (!m2_valid && k < 20) begin
      @(negedge i_clk);
      k++;
    end
    chk("narrow_valid", m2_valid, 1);
    chk("narrow_addr", m2_addr, 16'hBEEF);
    chk("narrow_size", m2_size, 16'h0102);
    chk("narrow_wr", m2_wr, 1);

    repeat (3) @(negedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
